// File: rtl/obi_scratch_responder_pkg.sv
// obi_scratch_responder_pkg: OBI bus types and response-stage type for the scratchpad responder
package obi_scratch_responder_pkg;
  localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_stage_t;
endpackage

// File: rtl/obi_resp_delay.sv
// obi_resp_delay: fixed-depth shift register of response stages, flushed by sync reset
module obi_resp_delay
  import obi_scratch_responder_pkg::*;
#(
  parameter int Depth = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  resp_stage_t i_stage,
  output resp_stage_t o_stage
);
  resp_stage_t r_pipe [Depth];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < Depth; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= i_stage;
      for (int k = 1; k < Depth; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end
  assign o_stage = r_pipe[Depth-1];
endmodule

// File: rtl/obi_scratch_responder.sv
// obi_scratch_responder: OBI word scratchpad with fixed-latency in-order responses and error counting
module obi_scratch_responder
  import obi_scratch_responder_pkg::*;
#(
  parameter logic [31:0] BaseAddr       = 32'h0,
  parameter int          NumWords       = 1024,
  parameter int          Latency        = 1,
  parameter int          MaxOutstanding = 2,
  parameter int          ErrCntW        = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  obi_req_t           obi_req_i,
  output obi_resp_t          obi_resp_o,
  input  logic               stall_i,
  output logic               err_o,
  output logic [ErrCntW-1:0] err_cnt_o,
  input  logic               err_clr_i
);
  localparam int IdxW = $clog2(NumWords);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  logic [31:0]        r_mem [NumWords];
  logic [31:0]        w_offset;
  logic [IdxW-1:0]    w_idx;
  logic               w_in_range;
  logic               w_gnt;
  logic               w_retire;
  logic [CntW-1:0]    r_inflight;
  logic [ErrCntW-1:0] r_err_cnt;
  resp_stage_t        w_stage_in;
  resp_stage_t        w_stage_out;
  assign w_offset   = obi_req_i.addr - BaseAddr;
  assign w_idx      = w_offset[2 +: IdxW];
  assign w_in_range = (obi_req_i.addr >= BaseAddr) && (34'(w_offset) < 34'(NumWords) * 34'd4);
  assign w_retire   = w_stage_out.valid;
  // A slot freed by this cycle's response can be reused by this cycle's grant
  assign w_gnt = obi_req_i.req & ~stall_i & ~rst_i &
                 ((r_inflight - CntW'(w_retire)) < CntW'(MaxOutstanding));
  always_ff @(posedge clk_i) begin
    if (w_gnt && obi_req_i.we && w_in_range)
      for (int b = 0; b < 4; b++)
        if (obi_req_i.be[b]) r_mem[w_idx][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
  end
  assign w_stage_in = '{
    valid: w_gnt,
    err:   w_gnt & ~w_in_range,
    rdata: !w_gnt ? 32'h0 : !w_in_range ? ERR_RDATA : obi_req_i.we ? 32'h0 : r_mem[w_idx]
  };
  obi_resp_delay #(.Depth(Latency)) u_delay (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_stage (w_stage_in),
    .o_stage (w_stage_out)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) r_inflight <= '0;
    else r_inflight <= r_inflight + CntW'(w_gnt) - CntW'(w_retire);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(w_retire && r_inflight == '0));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || err_clr_i) r_err_cnt <= '0;
    else if (w_stage_out.valid && w_stage_out.err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
  end
  assign obi_resp_o = '{gnt: w_gnt, rvalid: w_stage_out.valid, rdata: w_stage_out.rdata};
  assign err_o      = w_stage_out.valid & w_stage_out.err;
  assign err_cnt_o  = r_err_cnt;
endmodule
